// File: rtl/jump_target_pkg.sv
// Shared definitions for the jump target unit: mode encodings and result records.
package jump_target_pkg;

  localparam logic [1:0] MODE_NONE   = 2'd0;
  localparam logic [1:0] MODE_JUMP   = 2'd1;
  localparam logic [1:0] MODE_BRANCH = 2'd2;
  localparam logic [1:0] MODE_JR     = 2'd3;

  // Reference target width; the unit itself is parametrised and packs its own payload.
  localparam int JT_ADDR_W = 32;

  typedef struct packed {
    logic taken;
    logic misaligned;
  } jt_flags_t;

  typedef struct packed {
    logic [JT_ADDR_W-1:0] target;
    jt_flags_t            flags;
  } jt_result_t;

endpackage

// File: rtl/target_skid_buf.sv
// Two-entry valid/ready skid buffer (main output register plus one skid entry)
// with flush; every output is taken straight from a register.
module target_skid_buf #(
  parameter int W = 8
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_flush,
  input  logic         i_valid,
  output logic         o_ready,
  input  logic [W-1:0] i_data,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic         r_main_valid;
  logic         r_skid_valid;
  logic         r_ready;
  logic [W-1:0] r_main_data;
  logic [W-1:0] r_skid_data;

  logic         w_handoff;
  logic         w_accept;
  logic         w_main_valid;
  logic         w_skid_valid;
  logic [W-1:0] w_main_data;
  logic [W-1:0] w_skid_data;

  assign w_handoff = r_main_valid & i_ready;
  assign w_accept  = i_valid & r_ready & ~i_flush;

  // Next-state selection; r_ready mirrors an empty skid entry, so accepts only land here with skid free.
  always_comb begin
    w_main_valid = r_main_valid;
    w_skid_valid = r_skid_valid;
    w_main_data  = r_main_data;
    w_skid_data  = r_skid_data;
    if (i_flush) begin
      w_main_valid = 1'b0;
      w_skid_valid = 1'b0;
    end else if (r_skid_valid) begin
      if (w_handoff) begin
        w_main_data  = r_skid_data;
        w_main_valid = 1'b1;
        w_skid_valid = 1'b0;
      end else begin
        w_main_valid = r_main_valid;
      end
    end else if (w_accept) begin
      if (!r_main_valid || w_handoff) begin
        w_main_data  = i_data;
        w_main_valid = 1'b1;
      end else begin
        w_skid_data  = i_data;
        w_skid_valid = 1'b1;
      end
    end else if (w_handoff) begin
      w_main_valid = 1'b0;
    end else begin
      w_main_valid = r_main_valid;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_main_valid <= 1'b0;
      r_skid_valid <= 1'b0;
      r_ready      <= 1'b1;
      r_main_data  <= {W{1'b0}};
      r_skid_data  <= {W{1'b0}};
    end else begin
      r_main_valid <= w_main_valid;
      r_skid_valid <= w_skid_valid;
      r_ready      <= ~w_skid_valid;
      r_main_data  <= w_main_data;
      r_skid_data  <= w_skid_data;
    end
  end

  assign o_valid = r_main_valid;
  assign o_ready = r_ready;
  assign o_data  = r_main_data;

endmodule

// File: rtl/jump_target_unit.sv
// Registered next-fetch target generator for jump, branch, jump-register and
// fall-through, delivered to fetch through a two-entry skid buffer.
module jump_target_unit
  import jump_target_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int IDX_W  = 26,
  parameter int OFF_W  = 16,
  parameter int SHIFT  = 2,
  parameter int CNT_W  = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  input  logic              In_Valid,
  output logic              In_Ready,
  input  logic [1:0]        Mode,
  input  logic [ADDR_W-1:0] PC4,
  input  logic [IDX_W-1:0]  Index,
  input  logic [OFF_W-1:0]  Offset,
  input  logic [ADDR_W-1:0] RegAddr,
  input  logic              Cond,
  input  logic              Flush,
  output logic              Out_Valid,
  input  logic              Out_Ready,
  output logic [ADDR_W-1:0] Target,
  output logic              Taken,
  output logic              Misaligned,
  output logic [CNT_W-1:0]  RedirectCount
);

  localparam int PAY_W = ADDR_W + 2;
  // Masks stay valid at the IDX_W+SHIFT == ADDR_W and SHIFT == 0 extremes.
  localparam logic [ADDR_W-1:0] LOW_MASK = (ADDR_W'(1'b1) << SHIFT) - ADDR_W'(1'b1);
  localparam logic [ADDR_W-1:0] HI_MASK  = ~((ADDR_W'(1'b1) << (IDX_W + SHIFT)) - ADDR_W'(1'b1));

  logic [ADDR_W-1:0] w_idx_field;
  logic [ADDR_W-1:0] w_off_field;
  logic [ADDR_W-1:0] w_target;
  jt_flags_t         w_flags;
  logic [PAY_W-1:0]  w_in_data;
  logic [PAY_W-1:0]  w_out_data;
  logic              w_out_valid;
  logic              w_in_ready;
  logic              w_count_evt;
  logic [CNT_W-1:0]  r_redirect_cnt;

  assign w_idx_field = ADDR_W'(Index) << SHIFT;
  assign w_off_field = ADDR_W'($signed(Offset)) << SHIFT;

  // Target selection by instruction class.
  always_comb begin
    w_target           = PC4;
    w_flags.taken      = 1'b0;
    w_flags.misaligned = 1'b0;
    case (Mode)
      MODE_NONE: begin
        w_target      = PC4;
        w_flags.taken = 1'b0;
      end
      MODE_JUMP: begin
        w_target      = (PC4 & HI_MASK) | w_idx_field;
        w_flags.taken = 1'b1;
      end
      MODE_BRANCH: begin
        if (Cond) begin
          w_target      = PC4 + w_off_field;
          w_flags.taken = 1'b1;
        end else begin
          w_target      = PC4;
          w_flags.taken = 1'b0;
        end
      end
      MODE_JR: begin
        w_target           = RegAddr;
        w_flags.taken      = 1'b1;
        w_flags.misaligned = |(RegAddr & LOW_MASK);
      end
      default: begin
        w_target      = PC4;
        w_flags.taken = 1'b0;
      end
    endcase
  end

  assign w_in_data = {w_target, w_flags.taken, w_flags.misaligned};

  target_skid_buf #(
    .W(PAY_W)
  ) u_skid (
    .i_clk   (Clk),
    .i_rst_n (Reset_n),
    .i_flush (Flush),
    .i_valid (In_Valid),
    .o_ready (w_in_ready),
    .i_data  (w_in_data),
    .o_valid (w_out_valid),
    .i_ready (Out_Ready),
    .o_data  (w_out_data)
  );

  assign w_count_evt = w_out_valid & Out_Ready & w_out_data[1];

  // Saturating count of delivered taken results; flush leaves it alone.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_redirect_cnt <= {CNT_W{1'b0}};
    end else if (w_count_evt && (r_redirect_cnt != {CNT_W{1'b1}})) begin
      r_redirect_cnt <= r_redirect_cnt + CNT_W'(1'b1);
    end
  end

  assign In_Ready      = w_in_ready;
  assign Out_Valid     = w_out_valid;
  assign Target        = w_out_data[PAY_W-1:2];
  assign Taken         = w_out_data[1];
  assign Misaligned    = w_out_data[0];
  assign RedirectCount = r_redirect_cnt;

endmodule

// File: doc/jump_target_unit.md
# jump_target_unit

Parametrised, registered successor to the datapath's combinational jump shift-left-2. It computes the next-fetch target for jump, branch, jump-register and fall-through instructions with configurable address, index, offset and shift widths, and hands the result to fetch over a valid/ready handshake through a two-entry skid buffer. It sits between decode and the PC-select stage and carries flush, misalignment and redirect-count logic that the old shifter did not have.

## Interface
- ADDR_W, 32, PC/target width
- IDX_W, 26, jump index width; IDX_W+SHIFT <= ADDR_W
- OFF_W, 16, signed branch offset width; OFF_W+SHIFT <= ADDR_W
- SHIFT, 2, left shift applied to index/offset (word alignment)
- CNT_W, 16, redirect counter width
- Clk  in  1  single clock, rising edge
- Reset_n  in  1  asynchronous, active-low reset
- In_Valid  in  1  request valid
- In_Ready  out  1  block can accept a request
- Mode  in  2  0 NONE, 1 JUMP, 2 BRANCH, 3 JR
- PC4  in  ADDR_W  address of the next sequential instruction
- Index  in  IDX_W  jump index
- Offset  in  OFF_W  signed branch offset
- RegAddr  in  ADDR_W  jump-register source
- Cond  in  1  branch condition result
- Flush  in  1  discard all held and incoming requests
- Out_Valid  out  1  result valid
- Out_Ready  in  1  consumer accepts result
- Target  out  ADDR_W  next-fetch address
- Taken  out  1  target differs from sequential flow
- Misaligned  out  1  JR target low SHIFT bits non-zero
- RedirectCount  out  CNT_W  saturating count of delivered taken results

## Operation
- Target computation (combinational, then captured):
  - NONE: Target=PC4, Taken=0.
  - JUMP: Target={PC4[ADDR_W-1:IDX_W+SHIFT], Index, SHIFT'b0}, Taken=1.
  - BRANCH with Cond=1: Target=PC4+(sign-extend(Offset)<<SHIFT), modulo 2^ADDR_W with no overflow flag, Taken=1.
  - BRANCH with Cond=0: Target=PC4, Taken=0.
  - JR: Target=RegAddr, Taken=1, Misaligned=|RegAddr[SHIFT-1:0].
  - Misaligned is 0 for every mode except JR.
- Acceptance and buffering:
  - A request is accepted when In_Valid & In_Ready.
  - Storage is a main output register plus one skid entry; FIFO order is always preserved.
  - In_Ready=1 whenever the skid entry is empty.
  - An accepted request goes to the main register if it is empty or draining this cycle; otherwise it goes to the skid entry.
  - On a main-register handoff (Out_Valid & Out_Ready), the skid entry moves to the main register.
- Flush:
  - Invalidates the main register and the skid entry.
  - Overrides any acceptance in the same cycle; the request presented that cycle is dropped.
  - A handoff that occurs in the flush cycle still counts.
- RedirectCount increments on Out_Valid & Out_Ready & Taken, saturates at 2^CNT_W-1, and is not cleared by Flush.

## Timing
- Reset values: Out_Valid=0, Target=0, Taken=0, Misaligned=0, RedirectCount=0, skid empty, In_Ready=1 on the first cycle after reset release.
- Latency: a request accepted at edge N appears at the outputs after edge N, i.e. 1 cycle.
- Throughput: 1 request per cycle while Out_Ready=1.
- When Out_Ready drops, exactly one more request is absorbed into skid; In_Ready falls at the next edge.
- Target, Taken and Misaligned hold stable while Out_Valid=1 and Out_Ready=0.
- In_Ready and all outputs are driven from registers only; there is no combinational In_Valid→Out_Valid or Out_Ready→In_Ready path.
- Reset asserted mid-operation: all state returns to reset values immediately and any in-flight results are lost.

## Structure
- Shared package jump_target_pkg holds:
  - Mode encodings: MODE_NONE, MODE_JUMP, MODE_BRANCH, MODE_JR.
  - Result record typedef: target, taken, misaligned.
- One sub-module, target_skid_buf: a two-entry valid/ready skid buffer parametrised on payload width with flush. Instantiated once with payload ADDR_W+2.
- Target arithmetic stays in the top module.

## Test plan
- Reset release, then JUMP with PC4=0x4000_0010 and Index=0x0000040 → one cycle later Target=0x4000_0100, Taken=1, Out_Valid=1.
- BRANCH with PC4=0x0000_0100, Offset=0xFFFE, Cond=1 → Target=0x0000_00F8; same inputs with Cond=0 → Target=0x0000_0100, Taken=0.
- JR with RegAddr=0x0000_1002 → Target=0x0000_1002, Misaligned=1; JR with RegAddr=0x0000_1004 → Misaligned=0.
- Backpressure: hold Out_Ready=0 and stream 3 requests A, B, C → A and B are accepted, In_Ready=0 while C is held. Release Out_Ready → A, B, C are delivered in order on consecutive cycles.
- With 2 entries held, assert Flush together with In_Valid → Out_Valid=0 next cycle, the new request is dropped, and RedirectCount is unchanged.
- With CNT_W=2, deliver 5 taken results → RedirectCount reads 1, 2, 3, 3, 3; asserting Reset_n=0 mid-stream clears it to 0 at once.
